gost89_ecb_stream: RTL and testbench

GOST89_ECB_STREAM -- requirements
Module: gost89_ecb_stream

---
 rtl/gost89_ecb_stream.sv | 136 +++++++++++++
 tb/tb_gost89_ecb_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gost89_ecb_stream.sv
// Byte-stream wrapper around a 64-bit GOST 28147-89 ECB core: gathers 8 bytes (zero-padding
// a short final block), runs one core operation, then streams the 8 result bytes MSB first.
module gost89_ecb_stream #(
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        core_load,
    output logic [63:0] core_in,
    input  logic [63:0] core_out,
    input  logic        core_busy,
    output logic        err
);
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {FILL, LOAD, WAIT_HI, WAIT_LO, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [63:0]     in_shift_reg, out_shift_reg;
    logic [2:0]      byte_cnt_reg, out_cnt_reg;
    logic            last_reg, err_reg;
    logic [TW-1:0]   tmo_cnt_reg;

    logic            in_fire, out_fire, tmo_hit, block_end;
    logic [63:0]     shifted, padded;
    logic [2:0]      pad_bytes;

    assign in_fire   = in_valid && (state_reg == FILL);
    assign out_fire  = out_ready && (state_reg == DRAIN);
    assign tmo_hit   = (tmo_cnt_reg == TW'(WAIT_TIMEOUT - 1));
    assign block_end = in_fire && (in_last || byte_cnt_reg == 3'd7);

    // A short final block is left-aligned, so its unfilled low bytes come out as zero.
    assign shifted   = {in_shift_reg[55:0], in_data};
    assign pad_bytes = 3'd7 - byte_cnt_reg;
    assign padded    = shifted << {pad_bytes, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= FILL;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (block_end) state_next = LOAD;
            LOAD:    state_next = WAIT_HI;
            WAIT_HI: if (core_busy) state_next = WAIT_LO;
                     else if (tmo_hit) state_next = FILL;
            WAIT_LO: if (!core_busy) state_next = DRAIN;
                     else if (tmo_hit) state_next = FILL;
            DRAIN:   if (out_fire && out_cnt_reg == 3'd7) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        core_load = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_reg)
            FILL:  in_ready  = 1'b1;
            LOAD:  core_load = 1'b1;
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = last_reg && (out_cnt_reg == 3'd7);
            end
            default: ;
        endcase
        out_data = out_shift_reg[63:56];
        core_in  = in_shift_reg;
        err      = err_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_shift_reg  <= '0;
            out_shift_reg <= '0;
            byte_cnt_reg  <= '0;
            out_cnt_reg   <= '0;
            last_reg      <= 1'b0;
            err_reg       <= 1'b0;
            tmo_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                FILL: if (in_fire) begin
                    in_shift_reg <= in_last ? padded : shifted;
                    byte_cnt_reg <= block_end ? 3'd0 : byte_cnt_reg + 3'd1;
                    if (in_last) last_reg <= 1'b1;
                end
                LOAD: tmo_cnt_reg <= '0;
                WAIT_HI: begin
                    if (core_busy) begin
                        tmo_cnt_reg <= '0;
                    end else if (tmo_hit) begin
                        err_reg      <= 1'b1;
                        byte_cnt_reg <= '0;
                        last_reg     <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!core_busy) begin
                        out_shift_reg <= core_out;
                        out_cnt_reg   <= '0;
                    end else if (tmo_hit) begin
                        err_reg      <= 1'b1;
                        byte_cnt_reg <= '0;
                        last_reg     <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                DRAIN: if (out_fire) begin
                    out_shift_reg <= {out_shift_reg[55:0], 8'h00};
                    out_cnt_reg   <= out_cnt_reg + 3'd1;
                    if (out_cnt_reg == 3'd7) begin
                        byte_cnt_reg <= '0;
                        last_reg     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gost89_ecb_stream.sv
// Bench for gost89_ecb_stream. A simple stand-in core (busy for 4 cycles, result is a fixed
// rotate/xor of its input) replaces the cipher so every expected byte is easy to derive.
module tb_gost89_ecb_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        core_load;
    logic [63:0] core_in;
    logic [63:0] core_out;
    logic        core_busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    bit disc = 1'b0;

    gost89_ecb_stream #(.WAIT_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .core_load(core_load), .core_in(core_in), .core_out(core_out), .core_busy(core_busy),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] core_f(input logic [63:0] x);
        return {x[50:0], x[63:51]} ^ 64'h0123456789ABCDEF;
    endfunction

    logic [63:0] mock_in;
    logic [2:0]  mock_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_out  <= '0;
            mock_cnt  <= '0;
            mock_in   <= '0;
        end else if (core_load && !disc) begin
            core_busy <= 1'b1;
            mock_cnt  <= 3'd4;
            mock_in   <= core_in;
        end else if (core_busy) begin
            mock_cnt <= mock_cnt - 3'd1;
            if (mock_cnt == 3'd1) begin
                core_busy <= 1'b0;
                core_out  <= core_f(mock_in);
            end
        end
    end

    always @(posedge clk) if (core_load) load_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input logic l);
        int w = 0;
        in_data = b; in_valid = 1'b1; in_last = l;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic wait_load(input logic [63:0] exp_in);
        int w = 0;
        while (!core_load && w < 20) begin @(negedge clk); w++; end
        check("core_load_wait", {63'd0, core_load}, 64'd1);
        check("core_in", core_in, exp_in);
        check("in_ready_load", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic run_block(input logic [63:0] blk, input int nbytes, input bit last,
                             input bit toggle);
        int loads0 = load_cnt;
        int got = 0;
        int cyc = 0;
        logic [63:0] exp = core_f(blk);
        logic [63:0] seen = '0;
        bit rdy;
        for (int i = 0; i < nbytes; i++)
            send_byte(blk[63-8*i -: 8], last && (i == nbytes - 1));
        wait_load(blk);
        while (got < 8 && cyc < 200) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
                check("out_data", {56'd0, out_data}, {56'd0, exp[63-8*got -: 8]});
                check("out_last", {63'd0, out_last}, {63'd0, last && got == 7});
                check("in_ready_drain", {63'd0, in_ready}, 64'd0);
                if (rdy) begin seen = {seen[55:0], out_data}; got++; end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_bytes", 64'(got), 64'd8);
        check("load_pulses", 64'(load_cnt - loads0), 64'd1);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
        $display("block in=%h core_in=%h out=%h last=%0d", blk, blk, seen, last);
    endtask

    typedef struct {
        logic [63:0] blk;
        int          nbytes;
        bit          last;
        bit          toggle;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{64'hd5a8a608f4f115b4, 8, 1'b1, 1'b0};
        vecs[1] = '{64'h389eb44a391474c4, 8, 1'b0, 1'b0};
        vecs[2] = '{64'h379e59c3c96bb2ab, 8, 1'b0, 1'b0};
        vecs[3] = '{64'hd5a8a608f4f115b4, 8, 1'b1, 1'b1};
        vecs[4] = '{64'h3f38ae0000000000, 3, 1'b1, 1'b0};

        #1 reset = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_core_load", {63'd0, core_load}, 64'd0);
        check("rst_core_in", core_in, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++)
            run_block(vecs[v].blk, vecs[v].nbytes, vecs[v].last, vecs[v].toggle);

        // Reset five cycles into a core operation must drop the block entirely.
        for (int i = 0; i < 8; i++) send_byte(8'(64'h389eb44a391474c4 >> (56 - 8*i)), 1'b0);
        wait_load(64'h389eb44a391474c4);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_core_in", core_in, 64'd0);
        check("midrst_core_load", {63'd0, core_load}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        run_block(64'h3f38ae3b8f541361, 8, 1'b0, 1'b0);
        check("err_clean", {63'd0, err}, 64'd0);

        // Disconnected core: WAIT_HI must give up after 64 cycles.
        disc = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(64'h0011223344556677 >> (56 - 8*i)), 1'b1 && i == 7);
        wait_load(64'h0011223344556677);
        n = 0;
        while (!in_ready && n < 200) begin
            if (n == 64) check("err_before_timeout", {63'd0, err}, 64'd0);
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd65);
        check("timeout_err", {63'd0, err}, 64'd1);
        check("timeout_in_ready", {63'd0, in_ready}, 64'd1);
        check("timeout_out_valid", {63'd0, out_valid}, 64'd0);
        $display("timeout abort after %0d cycles err=%0d", n, err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
